// File: rtl/cpu_pause_gate_if.sv
// cpu_pause_gate_if
// Bundles the pause handshake and CPU strobe signals of cpu_pause_gate.
//   pause_req : pause request from the pause controller (level)
//   ce_in     : raw CPU clock-enable strobe
//   bus_idle  : CPU is between bus cycles (valid when ce_in=1)
//   vblank    : vertical blank level, clk_sys domain
//   ce_out    : gated CPU clock-enable
//   paused    : registered acknowledge, CPU halted
//   forced    : registered, current pause was entered on timeout
// The master modport drives requests/strobes; the slave modport is the gate.
interface cpu_pause_gate_if;
  logic pause_req;
  logic ce_in;
  logic bus_idle;
  logic vblank;
  logic ce_out;
  logic paused;
  logic forced;

  modport master (
    output pause_req, ce_in, bus_idle, vblank,
    input  ce_out, paused, forced
  );

  modport slave (
    input  pause_req, ce_in, bus_idle, vblank,
    output ce_out, paused, forced
  );
endinterface

// File: rtl/cpu_pause_gate.sv
// cpu_pause_gate
// Stops the CPU clock-enable only at a safe point (between bus cycles,
// optionally after a vblank rising edge) and acknowledges with `paused`.
// Ports:
//   clk_sys : system clock, all logic on rising edge
//   reset   : synchronous, active-high
//   pg      : cpu_pause_gate_if.slave (pause_req, ce_in, bus_idle, vblank in;
//             ce_out, paused, forced out)
// Parameters:
//   WAIT_MAX : passed strobes allowed in DRAIN before the pause is forced (1..65535)
//   VBL_SYNC : 1 = wait for a vblank rising edge before draining
module cpu_pause_gate #(
  parameter int WAIT_MAX = 1023,
  parameter bit VBL_SYNC = 1'b0
) (
  input logic          clk_sys,
  input logic          reset,
  cpu_pause_gate_if.slave pg
);

  localparam logic [15:0] WAIT_MAX_W = 16'(WAIT_MAX);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_ARM    = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_PAUSED = 2'd3
  } state_t;

  state_t      state_r;
  state_t      state_nxt_s;
  logic [15:0] wcnt_r;
  logic [15:0] wcnt_nxt_s;
  logic [15:0] wcnt_inc_s;
  logic        vblank_d_r;
  logic        paused_r;
  logic        forced_r;
  logic        forced_nxt_s;
  logic        ce_gate_s;
  logic        vbl_rise_s;

  assign vbl_rise_s = pg.vblank & ~vblank_d_r;
  // Saturating increment; the counter must never wrap.
  assign wcnt_inc_s = (wcnt_r == 16'hFFFF) ? wcnt_r : (wcnt_r + 16'd1);

  // Next-state, counter and gated strobe decode.
  always_comb begin
    state_nxt_s  = state_r;
    wcnt_nxt_s   = wcnt_r;
    forced_nxt_s = forced_r;
    ce_gate_s    = pg.ce_in;
    case (state_r)
      ST_RUN: begin
        if (pg.pause_req) begin
          state_nxt_s = VBL_SYNC ? ST_ARM : ST_DRAIN;
          wcnt_nxt_s  = 16'd0;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_ARM: begin
        if (!pg.pause_req) begin
          state_nxt_s = ST_RUN;
        end else if (vbl_rise_s) begin
          state_nxt_s = ST_DRAIN;
        end else begin
          state_nxt_s = ST_ARM;
        end
      end
      ST_DRAIN: begin
        // An idle strobe is only swallowed when the pause is actually taken;
        // if the request drops in the same cycle the strobe still passes.
        ce_gate_s = pg.ce_in & ~(pg.bus_idle & pg.pause_req);
        if (!pg.pause_req) begin
          state_nxt_s = ST_RUN;
        end else if (pg.ce_in && pg.bus_idle) begin
          state_nxt_s  = ST_PAUSED;
          forced_nxt_s = 1'b0;
        end else if (pg.ce_in) begin
          wcnt_nxt_s = wcnt_inc_s;
          if (wcnt_inc_s == WAIT_MAX_W) begin
            state_nxt_s  = ST_PAUSED;
            forced_nxt_s = 1'b1;
          end else begin
            state_nxt_s = ST_DRAIN;
          end
        end else begin
          state_nxt_s = ST_DRAIN;
        end
      end
      ST_PAUSED: begin
        ce_gate_s = 1'b0;
        if (!pg.pause_req) begin
          state_nxt_s  = ST_RUN;
          forced_nxt_s = 1'b0;
        end else begin
          state_nxt_s = ST_PAUSED;
        end
      end
      default: begin
        state_nxt_s  = ST_RUN;
        forced_nxt_s = 1'b0;
        ce_gate_s    = pg.ce_in;
      end
    endcase
  end

  // State, counter, edge-detect and acknowledge registers.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_r    <= ST_RUN;
      wcnt_r     <= 16'd0;
      vblank_d_r <= pg.vblank;
      paused_r   <= 1'b0;
      forced_r   <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      wcnt_r     <= wcnt_nxt_s;
      vblank_d_r <= pg.vblank;
      paused_r   <= (state_nxt_s == ST_PAUSED);
      forced_r   <= forced_nxt_s;
    end
  end

  // The CPU keeps clocking straight through reset.
  assign pg.ce_out = reset ? pg.ce_in : ce_gate_s;
  assign pg.paused = paused_r;
  assign pg.forced = forced_r;

endmodule

// File: tb/tb_cpu_pause_gate.sv
// Directed bench for cpu_pause_gate: instance ua (VBL_SYNC=0, WAIT_MAX=5)
// and instance ub (VBL_SYNC=1, default WAIT_MAX).
module tb_cpu_pause_gate;
  logic clk_sys = 1'b0;
  logic reset   = 1'b1;
  int   n_total = 0;
  int   n_pass  = 0;
  int   n_fail  = 0;
  int   n_ce;
  int   n_out;
  int   n_bad;

  cpu_pause_gate_if ia ();
  cpu_pause_gate_if ib ();

  cpu_pause_gate #(.WAIT_MAX(5), .VBL_SYNC(1'b0)) ua (
    .clk_sys(clk_sys), .reset(reset), .pg(ia)
  );
  cpu_pause_gate #(.WAIT_MAX(1023), .VBL_SYNC(1'b1)) ub (
    .clk_sys(clk_sys), .reset(reset), .pg(ib)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic chk(input string tag, input int obs, input int exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic set_a(input logic pr, input logic ce, input logic idle);
    ia.pause_req = pr;
    ia.ce_in     = ce;
    ia.bus_idle  = idle;
    #1;
  endtask

  task automatic set_b(input logic pr, input logic ce, input logic idle, input logic vb);
    ib.pause_req = pr;
    ib.ce_in     = ce;
    ib.bus_idle  = idle;
    ib.vblank    = vb;
    #1;
  endtask

  initial begin
    set_a(1'b0, 1'b0, 1'b0);
    set_b(1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    // reset state
    chk("rst_paused", int'(ia.paused), 0);
    chk("rst_forced", int'(ia.forced), 0);
    set_a(1'b0, 1'b1, 1'b1);
    chk("rst_ce_pass", int'(ia.ce_out), 1);
    tick();
    reset = 1'b0;
    set_a(1'b0, 1'b0, 1'b0);
    tick();

    // 1: three busy strobes pass, the idle one is blocked
    set_a(1'b1, 1'b0, 1'b0);
    tick();
    for (int s = 0; s < 3; s++) begin
      set_a(1'b1, 1'b1, 1'b0);
      chk("t1_busy_pass", int'(ia.ce_out), 1);
      tick();
      for (int k = 0; k < 3; k++) begin
        set_a(1'b1, 1'b0, 1'b0);
        tick();
      end
    end
    set_a(1'b1, 1'b1, 1'b1);
    chk("t1_idle_block", int'(ia.ce_out), 0);
    chk("t1_not_yet", int'(ia.paused), 0);
    tick();
    chk("t1_paused", int'(ia.paused), 1);
    chk("t1_forced", int'(ia.forced), 0);
    n_out = 0;
    for (int i = 0; i < 100; i++) begin
      set_a(1'b1, (i % 4) == 0, (i % 8) == 0);
      if (ia.ce_out) n_out++;
      tick();
    end
    chk("t1_hold_ce0", n_out, 0);
    chk("t1_hold_paused", int'(ia.paused), 1);
    set_a(1'b0, 1'b0, 1'b0);
    tick();
    chk("t1_exit_paused", int'(ia.paused), 0);

    // 2: timeout after WAIT_MAX=5 passed strobes
    set_a(1'b1, 1'b0, 1'b0);
    tick();
    for (int i = 0; i < 5; i++) begin
      set_a(1'b1, 1'b1, 1'b0);
      chk("t2_strobe_pass", int'(ia.ce_out), 1);
      tick();
      chk("t2_paused_step", int'(ia.paused), (i == 4) ? 1 : 0);
      set_a(1'b1, 1'b0, 1'b0);
      tick();
    end
    chk("t2_forced", int'(ia.forced), 1);
    set_a(1'b1, 1'b1, 1'b0);
    chk("t2_blocked", int'(ia.ce_out), 0);
    tick();
    set_a(1'b0, 1'b0, 1'b0);
    tick();
    chk("t2_exit_paused", int'(ia.paused), 0);
    chk("t2_exit_forced", int'(ia.forced), 0);
    set_a(1'b0, 1'b1, 1'b0);
    chk("t2_next_pass", int'(ia.ce_out), 1);
    tick();

    // 4: short pulse, no idle strobe
    n_ce = 0; n_out = 0; n_bad = 0;
    for (int i = 0; i < 6; i++) begin
      set_a(i < 2, 1'b1, i >= 3);
      n_ce++;
      if (ia.ce_out) n_out++;
      if (ia.paused) n_bad++;
      tick();
    end
    chk("t4_all_pass", n_out, n_ce);
    chk("t4_no_paused", n_bad, 0);

    // 6: request drop coincides with idle strobe in DRAIN
    set_a(1'b1, 1'b0, 1'b0);
    tick();
    set_a(1'b0, 1'b1, 1'b1);
    chk("t6_strobe_pass", int'(ia.ce_out), 1);
    tick();
    chk("t6_no_paused", int'(ia.paused), 0);
    set_a(1'b0, 1'b1, 1'b1);
    chk("t6_run_pass", int'(ia.ce_out), 1);
    tick();

    // 5: reset while paused with request held
    set_a(1'b1, 1'b0, 1'b0);
    tick();
    set_a(1'b1, 1'b1, 1'b1);
    tick();
    chk("t5_paused", int'(ia.paused), 1);
    reset = 1'b1;
    set_a(1'b1, 1'b1, 1'b1);
    chk("t5_rst_ce", int'(ia.ce_out), 1);
    tick();
    reset = 1'b0;
    chk("t5_rst_paused", int'(ia.paused), 0);
    chk("t5_rst_forced", int'(ia.forced), 0);
    set_a(1'b1, 1'b1, 1'b1);
    chk("t5_run_pass", int'(ia.ce_out), 1);
    tick();
    set_a(1'b1, 1'b1, 1'b1);
    chk("t5_reblock", int'(ia.ce_out), 0);
    tick();
    chk("t5_repaused", int'(ia.paused), 1);
    set_a(1'b0, 1'b0, 1'b0);
    tick();

    // 3: vblank-synchronised entry
    set_b(1'b1, 1'b0, 1'b1, 1'b0);
    tick();
    n_ce = 0; n_out = 0; n_bad = 0;
    for (int i = 0; i < 200; i++) begin
      set_b(1'b1, (i % 4) == 0, 1'b1, 1'b0);
      if (ib.ce_in) n_ce++;
      if (ib.ce_out) n_out++;
      if (ib.paused) n_bad++;
      tick();
    end
    chk("t3_arm_count", n_ce, 50);
    chk("t3_arm_pass", n_out, 50);
    chk("t3_arm_no_paused", n_bad, 0);
    set_b(1'b1, 1'b1, 1'b1, 1'b1);
    chk("t3_rise_pass", int'(ib.ce_out), 1);
    tick();
    set_b(1'b1, 1'b1, 1'b1, 1'b1);
    chk("t3_drain_block", int'(ib.ce_out), 0);
    tick();
    chk("t3_paused", int'(ib.paused), 1);
    chk("t3_forced", int'(ib.forced), 0);
    set_b(1'b0, 1'b0, 1'b1, 1'b1);
    tick();
    chk("t3_exit", int'(ib.paused), 0);
    // vblank already high: a level without a rising edge must not drain
    n_out = 0;
    for (int i = 0; i < 8; i++) begin
      set_b(1'b1, (i % 2) == 1, 1'b1, 1'b1);
      if (ib.ce_out) n_out++;
      tick();
    end
    chk("t3_level_pass", n_out, 4);
    chk("t3_level_no_paused", int'(ib.paused), 0);
    set_b(1'b0, 1'b0, 1'b0, 1'b0);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
